img_loader: RTL and testbench

Parametrised boot-image loader between the UART receiver and the MCU program/data memories; it generalises the fixed 18-bit/16-bit image receive path inside `mcu`. It hunts for the `55 AA` sync pattern in the received byte stream, parses a size header, and assembles bytes into words of configurable width. Assembled words are written into pmem and dmem, and the loader verifies a trailing checksum. The CPU is held in reset while loading and after any failed load.

---
 rtl/img_loader.sv | 180 ++++++++++++++++++
 tb/tb_img_loader.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/img_loader.sv
// Boot-image loader: syncs on 55 AA, parses sizes, assembles bytes into pmem/dmem words, checks the checksum.
// Writes land one cycle after a word's last byte; no backpressure, so a byte per cycle is always absorbed.
module img_loader #(
    parameter int ADDR_WIDTH     = 16,
    parameter int PMEM_WIDTH     = 18,
    parameter int DMEM_WIDTH     = 16,
    parameter int PMEM_DEPTH     = 4096,
    parameter int DMEM_DEPTH     = 4096,
    parameter int TIMEOUT_CYCLES = 270000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            rx_byte,
    input  logic                  rx_valid,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  pmem_we,
    output logic [PMEM_WIDTH-1:0] pmem_wdata,
    output logic                  dmem_we,
    output logic [DMEM_WIDTH-1:0] dmem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  err,
    output logic [1:0]            err_code
);

    localparam int PB = (PMEM_WIDTH + 7) / 8;
    localparam int DB = (DMEM_WIDTH + 7) / 8;
    localparam logic [1:0] PB_LAST = 2'(PB - 1);
    localparam logic [1:0] DB_LAST = 2'(DB - 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TLIMIT = TW'(TIMEOUT_CYCLES);
    localparam logic [ADDR_WIDTH-1:0] A_ONE = ADDR_WIDTH'(1);

    typedef enum logic [2:0] {IDLE, SYNC1, META, PMEM, DMEM, CSUM, FIN} state_t;

    state_t                state, state_nxt, eff;
    logic [ADDR_WIDTH-1:0] word_idx, psize, dsize, dsize_new;
    logic [1:0]            meta_cnt, bcnt, code_nxt;
    logic [7:0]            meta_hi, csum, csum_sum;
    logic [23:0]           shreg;
    logic [TW-1:0]         tcnt;
    logic                  sec_end, byte_last, loading;
    logic                  wr_p, wr_d, fire_err, fire_done;

    assign csum_sum  = csum + rx_byte;
    assign dsize_new = ADDR_WIDTH'({meta_hi, rx_byte});
    assign mem_addr  = (state == PMEM || state == DMEM) ? word_idx : '0;

    // A section ends in the cycle its last word is written; a byte arriving in
    // that same cycle already belongs to the following section (eff).
    always_comb begin
        eff     = state;
        sec_end = 1'b0;
        if (state == PMEM && pmem_we && (word_idx + A_ONE) == psize) begin
            sec_end = 1'b1;
            eff     = (dsize != '0) ? DMEM : CSUM;
        end else if (state == DMEM && dmem_we && (word_idx + A_ONE) == dsize) begin
            sec_end = 1'b1;
            eff     = CSUM;
        end
        state_nxt = eff;
        byte_last = (eff == PMEM) ? (bcnt == PB_LAST) : (bcnt == DB_LAST);
        loading   = (eff inside {META, PMEM, DMEM, CSUM});
        wr_p      = 1'b0;
        wr_d      = 1'b0;
        fire_err  = 1'b0;
        fire_done = 1'b0;
        code_nxt  = 2'd0;
        case (eff)
            IDLE:  if (rx_valid && rx_byte == 8'h55) state_nxt = SYNC1;
            SYNC1: if (rx_valid) begin
                       if (rx_byte == 8'hAA)      state_nxt = META;
                       else if (rx_byte != 8'h55) state_nxt = IDLE;
                   end
            META:  if (rx_valid && meta_cnt == 2'd3) begin
                       if (32'(psize) > 32'(PMEM_DEPTH) || 32'(dsize_new) > 32'(DMEM_DEPTH)) begin
                           state_nxt = IDLE;
                           fire_err  = 1'b1;
                           code_nxt  = 2'd1;
                       end else if (psize != '0)     state_nxt = PMEM;
                       else if (dsize_new != '0)     state_nxt = DMEM;
                       else                          state_nxt = CSUM;
                   end
            PMEM:  wr_p = rx_valid && byte_last;
            DMEM:  wr_d = rx_valid && byte_last;
            CSUM:  if (rx_valid) begin
                       if (csum_sum == 8'h00) begin
                           state_nxt = FIN;
                           fire_done = 1'b1;
                       end else begin
                           state_nxt = IDLE;
                           fire_err  = 1'b1;
                           code_nxt  = 2'd3;
                       end
                   end
            FIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (loading && !rx_valid && tcnt >= TLIMIT) begin
            state_nxt = IDLE;
            fire_err  = 1'b1;
            code_nxt  = 2'd2;
            wr_p      = 1'b0;
            wr_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pmem_we    <= 1'b0;
            dmem_we    <= 1'b0;
            pmem_wdata <= '0;
            dmem_wdata <= '0;
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_code   <= 2'd0;
            word_idx   <= '0;
            psize      <= '0;
            dsize      <= '0;
            meta_cnt   <= 2'd0;
            meta_hi    <= 8'h00;
            bcnt       <= 2'd0;
            csum       <= 8'h00;
            shreg      <= '0;
            tcnt       <= '0;
        end else begin
            pmem_we <= wr_p;
            dmem_we <= wr_d;
            done    <= fire_done;
            err     <= fire_err;
            if (wr_p) pmem_wdata <= PMEM_WIDTH'({shreg, rx_byte});
            if (wr_d) dmem_wdata <= DMEM_WIDTH'({shreg, rx_byte});

            if (sec_end || fire_err)     word_idx <= '0;
            else if (pmem_we || dmem_we) word_idx <= word_idx + A_ONE;

            if (rx_valid && (eff == PMEM || eff == DMEM)) begin
                shreg <= {shreg[15:0], rx_byte};
                bcnt  <= byte_last ? 2'd0 : bcnt + 2'd1;
            end
            if (rx_valid && (eff == META || eff == PMEM || eff == DMEM)) csum <= csum_sum;

            if (rx_valid && eff == META) begin
                meta_cnt <= meta_cnt + 2'd1;
                case (meta_cnt)
                    2'd0:    meta_hi <= rx_byte;
                    2'd1:    psize   <= ADDR_WIDTH'({meta_hi, rx_byte});
                    2'd2:    meta_hi <= rx_byte;
                    default: dsize   <= dsize_new;
                endcase
            end

            tcnt <= (rx_valid || !loading || fire_err) ? '0 : tcnt + TW'(1);

            if (fire_err) begin
                err_code <= code_nxt;
                bcnt     <= 2'd0;
            end
            if (state == FIN) begin
                cpu_hold <= 1'b0;
                err_code <= 2'd0;
            end
            if (eff == SYNC1 && rx_valid && rx_byte == 8'hAA) begin
                cpu_hold <= 1'b1;
                csum     <= 8'h00;
                meta_cnt <= 2'd0;
                bcnt     <= 2'd0;
                word_idx <= '0;
                shreg    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_img_loader.sv
// Directed bench for img_loader: vector table of whole images plus hand sequences for timing corners.
module tb_img_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        rx_valid = 1'b0;
    logic [15:0] mem_addr;
    logic        pmem_we, dmem_we, cpu_hold, done, err;
    logic [17:0] pmem_wdata;
    logic [15:0] dmem_wdata;
    logic [1:0]  err_code;

    img_loader #(.TIMEOUT_CYCLES(40)) dut (
        .clk(clk), .rst_n(rst_n), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .mem_addr(mem_addr), .pmem_we(pmem_we), .pmem_wdata(pmem_wdata),
        .dmem_we(dmem_we), .dmem_wdata(dmem_wdata), .cpu_hold(cpu_hold),
        .done(done), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               n;
        logic [127:0]     img;
        int               pw;
        int               dw;
        logic [1:0][31:0] pd;
        logic [31:0]      dd;
        int               dn;
        int               er;
        logic [1:0]       code;
        logic             hold;
    } vec_t;

    vec_t vecs[9];
    int total = 0, bad = 0;

    logic [15:0] pw_a[$];
    logic [31:0] pw_d[$];
    logic [15:0] dw_a[$];
    logic [31:0] dw_d[$];
    int done_cnt = 0, err_cnt = 0, excl_viol = 0;

    always @(negedge clk) begin
        if (pmem_we) begin pw_a.push_back(mem_addr); pw_d.push_back(32'(pmem_wdata)); end
        if (dmem_we) begin dw_a.push_back(mem_addr); dw_d.push_back(32'(dmem_wdata)); end
        if (done) done_cnt <= done_cnt + 1;
        if (err)  err_cnt  <= err_cnt + 1;
        if (pmem_we && dmem_we) excl_viol <= excl_viol + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic run_vec(input int i);
        int p0, d0, dn0, er0;
        p0 = pw_a.size(); d0 = dw_a.size(); dn0 = done_cnt; er0 = err_cnt;
        for (int k = 0; k < vecs[i].n; k++) send(vecs[i].img[8*(vecs[i].n-1-k) +: 8]);
        idle(4);
        chk($sformatf("v%0d_pw_cnt", i), 32'(pw_a.size() - p0), 32'(vecs[i].pw));
        chk($sformatf("v%0d_dw_cnt", i), 32'(dw_a.size() - d0), 32'(vecs[i].dw));
        for (int k = 0; k < vecs[i].pw && p0 + k < pw_a.size(); k++) begin
            chk($sformatf("v%0d_pw_addr%0d", i, k), 32'(pw_a[p0+k]), 32'(k));
            chk($sformatf("v%0d_pw_data%0d", i, k), pw_d[p0+k], vecs[i].pd[k]);
        end
        if (vecs[i].dw > 0 && dw_a.size() > d0) begin
            chk($sformatf("v%0d_dw_addr", i), 32'(dw_a[d0]), 32'd0);
            chk($sformatf("v%0d_dw_data", i), dw_d[d0], vecs[i].dd);
        end
        chk($sformatf("v%0d_done", i), 32'(done_cnt - dn0), 32'(vecs[i].dn));
        chk($sformatf("v%0d_err", i), 32'(err_cnt - er0), 32'(vecs[i].er));
        chk($sformatf("v%0d_code", i), 32'(err_code), 32'(vecs[i].code));
        chk($sformatf("v%0d_hold", i), 32'(cpu_hold), 32'(vecs[i].hold));
    endtask

    initial begin
        int j;
        bit seen;
        int p0;

        vecs[0] = '{n:15, img:128'h55AA_0002_0001_03FFFF_000001_1234_B5, pw:2, dw:1,
                    pd:{32'h1, 32'h3FFFF}, dd:32'h1234, dn:1, er:0, code:2'd0, hold:1'b0};
        vecs[1] = '{n:15, img:128'h55AA_0002_0001_03FFFF_000001_1234_B4, pw:2, dw:1,
                    pd:{32'h1, 32'h3FFFF}, dd:32'h1234, dn:0, er:1, code:2'd3, hold:1'b1};
        vecs[2] = vecs[0];
        vecs[3] = '{n:6, img:128'h55AA_1001_0000, pw:0, dw:0,
                    pd:'0, dd:32'h0, dn:0, er:1, code:2'd1, hold:1'b1};
        vecs[4] = '{n:6, img:128'h55AA_0000_1001, pw:0, dw:0,
                    pd:'0, dd:32'h0, dn:0, er:1, code:2'd1, hold:1'b1};
        vecs[5] = '{n:7, img:128'h55AA_0000_0000_00, pw:0, dw:0,
                    pd:'0, dd:32'h0, dn:1, er:0, code:2'd0, hold:1'b0};
        vecs[6] = '{n:8, img:128'h5555AA_0000_0000_00, pw:0, dw:0,
                    pd:'0, dd:32'h0, dn:1, er:0, code:2'd0, hold:1'b0};
        vecs[7] = '{n:8, img:128'h5512AA_0000_0000_00, pw:0, dw:0,
                    pd:'0, dd:32'h0, dn:0, er:0, code:2'd0, hold:1'b0};
        vecs[8] = '{n:10, img:128'h55AA_0001_0000_0055AA_00, pw:1, dw:0,
                    pd:{32'h0, 32'h055AA}, dd:32'h0, dn:1, er:0, code:2'd0, hold:1'b0};

        // reset values
        #2;
        chk("rst_hold", 32'(cpu_hold), 32'd0);
        chk("rst_we", 32'({pmem_we, dmem_we, done, err}), 32'd0);
        chk("rst_code", 32'(err_code), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", 32'(pmem_wdata) | 32'(dmem_wdata), 32'd0);
        idle(2);
        rst_n = 1'b1;
        idle(2);

        // cycle-accurate walk through the reference image, streamed back-to-back
        send(8'h55); send(8'hAA);
        chk("hold_after_aa", 32'(cpu_hold), 32'd1);
        send(8'h00); send(8'h02); send(8'h00); send(8'h01);
        send(8'h03); send(8'hFF); send(8'hFF);
        chk("p0_we", 32'(pmem_we), 32'd1);
        chk("p0_addr", 32'(mem_addr), 32'd0);
        chk("p0_data", 32'(pmem_wdata), 32'h3FFFF);
        send(8'h00);
        chk("p0_we_pulse", 32'(pmem_we), 32'd0);
        chk("p0_data_hold", 32'(pmem_wdata), 32'h3FFFF);
        chk("p1_addr_pre", 32'(mem_addr), 32'd1);
        send(8'h00); send(8'h01);
        chk("p1_we", 32'(pmem_we), 32'd1);
        chk("p1_addr", 32'(mem_addr), 32'd1);
        chk("p1_data", 32'(pmem_wdata), 32'h1);
        send(8'h12);
        chk("d_enter_pwe", 32'(pmem_we), 32'd0);
        chk("d_enter_addr", 32'(mem_addr), 32'd0);
        send(8'h34);
        chk("d0_we", 32'(dmem_we), 32'd1);
        chk("d0_addr", 32'(mem_addr), 32'd0);
        chk("d0_data", 32'(dmem_wdata), 32'h1234);
        send(8'hB5);
        chk("fin_done", 32'(done), 32'd1);
        chk("fin_dwe", 32'(dmem_we), 32'd0);
        idle(1);
        chk("fin_done_pulse", 32'(done), 32'd0);
        chk("fin_hold", 32'(cpu_hold), 32'd0);
        idle(3);

        for (int i = 0; i < 9; i++) begin
            run_vec(i);
            idle(2);
        end

        // stall after the second pmem byte
        p0 = pw_a.size();
        send(8'h55); send(8'hAA); send(8'h00); send(8'h02); send(8'h00); send(8'h01);
        send(8'h03); send(8'hFF);
        j = 0; seen = 1'b0;
        while (!seen && j < 200) begin
            idle(1);
            j++;
            if (err) seen = 1'b1;
        end
        chk("to_seen", 32'(seen), 32'd1);
        chk("to_latency", 32'(j), 32'd41);
        chk("to_code", 32'(err_code), 32'd2);
        chk("to_no_write", 32'(pw_a.size() - p0), 32'd0);
        chk("to_hold", 32'(cpu_hold), 32'd1);
        idle(2);
        run_vec(0);
        idle(2);

        // reset in the middle of the dmem section
        for (int k = 0; k < 13; k++) send(vecs[0].img[8*(14-k) +: 8]);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_hold", 32'(cpu_hold), 32'd0);
        chk("mid_rst_we", 32'({pmem_we, dmem_we, done, err}), 32'd0);
        chk("mid_rst_addr", 32'(mem_addr), 32'd0);
        chk("mid_rst_wdata", 32'(pmem_wdata) | 32'(dmem_wdata), 32'd0);
        chk("mid_rst_code", 32'(err_code), 32'd0);
        p0 = dw_a.size();
        j = done_cnt;
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(8'h34); send(8'hB5);
        idle(4);
        chk("mid_rst_no_dw", 32'(dw_a.size() - p0), 32'd0);
        chk("mid_rst_no_done", 32'(done_cnt - j), 32'd0);
        chk("we_exclusive", 32'(excl_viol), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
